// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - PS/2 set-2 prefix constants, event layout and decoder state type
package kbd_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // Controller status bytes: ack, echo, resend, self-test passed
    localparam logic [7:0] PS2_STAT_ACK    = 8'hFA;
    localparam logic [7:0] PS2_STAT_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_STAT_RESEND = 8'hFE;
    localparam logic [7:0] PS2_STAT_BAT_OK = 8'hAA;

    localparam int EVT_BRK = 15;
    localparam int EVT_EXT = 14;

    localparam logic [15:0] PAUSE_EVENT = 16'h40E1;
    localparam logic [2:0]  PAUSE_SKIP  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } kbd_dec_state_t;

    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_STAT_ACK) || (b == PS2_STAT_ECHO) ||
               (b == PS2_STAT_RESEND) || (b == PS2_STAT_BAT_OK);
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - generic show-ahead synchronous FIFO with separate occupancy count
module kbd_fifo #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop,
    input  logic              clear,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full queue still accepts a push when the head leaves on the same edge
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/kbd_event_queue.sv
// rtl/kbd_event_queue.sv - folds PS/2 prefix bytes into key events and queues them for the CPU
module kbd_event_queue
    import kbd_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic [7:0]        ps2_data,
    input  logic              ps2_data_en,
    input  logic              clear,
    input  logic              rd_en,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              irq
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    kbd_dec_state_t state;
    kbd_dec_state_t state_next;
    logic [2:0]       skip;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             evt_valid;
    logic [15:0]      evt_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_ok;

    assign tmo_hit = (state != IDLE) && !ps2_data_en &&
                     (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst)        state <= IDLE;
        else if (clear) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (ps2_data_en) begin
            case (state)
                IDLE: begin
                    if (ps2_data == PS2_PFX_EXT)        state_next = EXT;
                    else if (ps2_data == PS2_PFX_BRK)   state_next = BRK;
                    else if (ps2_data == PS2_PFX_PAUSE) state_next = PAUSE;
                end
                EXT: begin
                    if (ps2_data == PS2_PFX_BRK)       state_next = EXT_BRK;
                    else if (ps2_data != PS2_PFX_EXT)  state_next = IDLE;
                end
                BRK, EXT_BRK: state_next = IDLE;
                PAUSE:   if (skip == 3'd1) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_next = IDLE;
        end
    end

    // Mealy output: the event is pushed on the same edge that samples its final byte
    always_comb begin
        evt_valid = 1'b0;
        evt_data  = {8'h00, ps2_data};
        if (ps2_data_en) begin
            case (state)
                IDLE: evt_valid = !is_status_byte(ps2_data) &&
                                  (ps2_data != PS2_PFX_EXT) &&
                                  (ps2_data != PS2_PFX_BRK) &&
                                  (ps2_data != PS2_PFX_PAUSE);
                EXT: begin
                    evt_valid          = (ps2_data != PS2_PFX_BRK) && (ps2_data != PS2_PFX_EXT);
                    evt_data[EVT_EXT]  = 1'b1;
                end
                BRK: begin
                    evt_valid          = 1'b1;
                    evt_data[EVT_BRK]  = 1'b1;
                end
                EXT_BRK: begin
                    evt_valid          = 1'b1;
                    evt_data[EVT_BRK]  = 1'b1;
                    evt_data[EVT_EXT]  = 1'b1;
                end
                PAUSE: begin
                    evt_valid = (skip == 3'd1);
                    evt_data  = PAUSE_EVENT;
                end
                default: evt_valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            skip <= '0;
        end else if (ps2_data_en) begin
            if (state == IDLE && ps2_data == PS2_PFX_PAUSE) skip <= PAUSE_SKIP;
            else if (state == PAUSE)                        skip <= skip - 3'd1;
        end
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst)                                            tmo_cnt <= '0;
        else if (clear || state == IDLE || ps2_data_en || tmo_hit) tmo_cnt <= '0;
        else                                                tmo_cnt <= tmo_cnt + 1'b1;
    end

    kbd_fifo #(
        .WIDTH  (16),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk50),
        .rst   (rst),
        .push  (evt_valid),
        .wdata (evt_data),
        .pop   (rd_en),
        .clear (clear),
        .rdata (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rd_valid = !fifo_empty;
    assign pop_ok   = rd_en && !fifo_empty;

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= !clear && fifo_empty && evt_valid;
            if (clear)
                overflow <= 1'b0;
            else if (evt_valid && fifo_full && !pop_ok)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_kbd_event_queue.sv
// tb/tb_kbd_event_queue.sv - directed self-checking bench for kbd_event_queue
module tb_kbd_event_queue;

    localparam int TMO = 32;

    logic        clk50 = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ps2_data = 8'h00;
    logic        ps2_data_en = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        overflow;
    logic        irq;

    int checks = 0;
    int errors = 0;

    kbd_event_queue #(
        .DEPTH   (16),
        .ADDR_W  (4),
        .TIMEOUT (TMO)
    ) dut (
        .clk50       (clk50),
        .rst         (rst),
        .ps2_data    (ps2_data),
        .ps2_data_en (ps2_data_en),
        .clear       (clear),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .overflow    (overflow),
        .irq         (irq)
    );

    always #10 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk50);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_data    = b;
        ps2_data_en = 1'b1;
        cyc();
        ps2_data_en = 1'b0;
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
    endtask

    initial begin
        cyc();
        chk("rst_rd_valid", 16'(rd_valid), 16'd0);
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_overflow", 16'(overflow), 16'd0);
        chk("rst_irq", 16'(irq), 16'd0);
        rst = 1'b0;
        cyc();

        send(8'h1C);
        chk("make_valid", 16'(rd_valid), 16'd1);
        chk("make_data", rd_data, 16'h001C);
        chk("make_count", 16'(count), 16'd1);
        chk("make_irq", 16'(irq), 16'd1);
        cyc();
        chk("irq_one_cycle", 16'(irq), 16'd0);
        pop1();
        chk("pop_valid", 16'(rd_valid), 16'd0);
        chk("pop_count", 16'(count), 16'd0);
        chk("pop_data", rd_data, 16'h0000);

        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h74);
        send(8'hFA); send(8'hAA);
        chk("seq_count", 16'(count), 16'd3);
        chk("seq_ev0", rd_data, 16'h801C);
        pop1();
        chk("seq_ev1", rd_data, 16'h4075);
        pop1();
        chk("seq_ev2", rd_data, 16'hC074);
        pop1();
        chk("seq_drained", 16'(count), 16'd0);

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0);
        chk("pause_partial", 16'(count), 16'd0);
        send(8'h77);
        chk("pause_count", 16'(count), 16'd1);
        chk("pause_data", rd_data, 16'h40E1);
        pop1();

        send(8'hE0);
        repeat (TMO + 1) cyc();
        send(8'h1C);
        chk("tmo_count", 16'(count), 16'd1);
        chk("tmo_data", rd_data, 16'h001C);
        pop1();

        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        chk("full_count", 16'(count), 16'd16);
        chk("full_head", rd_data, 16'h0010);
        ps2_data = 8'h31; ps2_data_en = 1'b1; rd_en = 1'b1;
        cyc();
        ps2_data_en = 1'b0; rd_en = 1'b0;
        chk("fullpp_count", 16'(count), 16'd16);
        chk("fullpp_ovf", 16'(overflow), 16'd0);
        chk("fullpp_head", rd_data, 16'h0011);
        send(8'h30);
        chk("ovf_count", 16'(count), 16'd16);
        chk("ovf_flag", 16'(overflow), 16'd1);
        chk("ovf_head", rd_data, 16'h0011);
        for (int i = 0; i < 15; i++) pop1();
        chk("tail_data", rd_data, 16'h0031);
        chk("tail_count", 16'(count), 16'd1);

        ps2_data = 8'h45; ps2_data_en = 1'b1; rd_en = 1'b1;
        cyc();
        ps2_data_en = 1'b0; rd_en = 1'b0;
        chk("pp1_count", 16'(count), 16'd1);
        chk("pp1_head", rd_data, 16'h0045);
        chk("pp1_irq", 16'(irq), 16'd0);

        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_count", 16'(count), 16'd0);
        chk("clr_ovf", 16'(overflow), 16'd0);
        chk("clr_valid", 16'(rd_valid), 16'd0);

        ps2_data = 8'h22; ps2_data_en = 1'b1; clear = 1'b1;
        cyc();
        ps2_data_en = 1'b0; clear = 1'b0;
        chk("clr_beats_push", 16'(count), 16'd0);
        chk("clr_no_irq", 16'(irq), 16'd0);

        send(8'h1C);
        send(8'hE0);
        rst = 1'b1;
        #1;
        chk("arst_count", 16'(count), 16'd0);
        chk("arst_valid", 16'(rd_valid), 16'd0);
        chk("arst_data", rd_data, 16'h0000);
        cyc();
        rst = 1'b0;
        cyc();
        send(8'h74);
        chk("post_rst_data", rd_data, 16'h0074);
        chk("post_rst_count", 16'(count), 16'd1);
        chk("post_rst_irq", 16'(irq), 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
